// File: rtl/issue_rat_freelist_mp_if.sv
// Rename-stage <-> free-list request/offer bundle for issue_rat_freelist_mp.
// o_free_count exists only when ISSUE_RAT_FREELIST_FREE_COUNT_EN is defined.
interface issue_rat_freelist_mp_if #(
  parameter int P_PRF_COUNT     = 64,
  parameter int P_FGR_COUNT     = 8,
  parameter int P_ACQUIRE_PORTS = 2
);
  localparam int PW = $clog2(P_PRF_COUNT);
  localparam int GW = $clog2(P_FGR_COUNT);

  logic [PW-1:0]                 i_redeemed_prf;
  logic                          i_redeemed_valid;
  logic                          o_redeemed_ready;
  logic [P_ACQUIRE_PORTS*PW-1:0] o_acquire_prf;
  logic [P_ACQUIRE_PORTS-1:0]    o_acquire_ready;
  logic [P_ACQUIRE_PORTS*GW-1:0] i_acquire_fgr;
  logic [P_ACQUIRE_PORTS-1:0]    i_acquire_fgr_speculative;
  logic [P_ACQUIRE_PORTS-1:0]    i_acquire_valid;
  logic [GW-1:0]                 i_commit_fgr;
  logic                          i_commit_valid;
  logic [GW-1:0]                 i_abandon_fgr;
  logic                          i_abandon_valid;
`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
  logic [PW:0]                   o_free_count;
`endif

  modport master (
`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
    input  o_free_count,
`endif
    output i_redeemed_prf, i_redeemed_valid,
    input  o_redeemed_ready, o_acquire_prf, o_acquire_ready,
    output i_acquire_fgr, i_acquire_fgr_speculative, i_acquire_valid,
    output i_commit_fgr, i_commit_valid, i_abandon_fgr, i_abandon_valid
  );

  modport slave (
`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
    output o_free_count,
`endif
    input  i_redeemed_prf, i_redeemed_valid,
    output o_redeemed_ready, o_acquire_prf, o_acquire_ready,
    input  i_acquire_fgr, i_acquire_fgr_speculative, i_acquire_valid,
    input  i_commit_fgr, i_commit_valid, i_abandon_fgr, i_abandon_valid
  );
endinterface

// File: rtl/issue_rat_freelist_mp.sv
// Multi-port PRF free list with per-PRF speculation tags (commit / abandon by FGR).
// Optional registered free-count output: define ISSUE_RAT_FREELIST_FREE_COUNT_EN.
module issue_rat_freelist_mp #(
  parameter int P_PRF_COUNT       = 64,
  parameter int P_FGR_COUNT       = 8,
  parameter int P_RESET_ALLOCATED = 32,
  parameter int P_ACQUIRE_PORTS   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  issue_rat_freelist_mp_if.slave  bus
);
  localparam int PW = $clog2(P_PRF_COUNT);
  localparam int GW = $clog2(P_FGR_COUNT);

  logic [P_PRF_COUNT-1:0] free_q, free_d;
  logic [P_PRF_COUNT-1:0] spec_q, spec_d;
  logic [GW-1:0]          tag_q [P_PRF_COUNT];
  logic [GW-1:0]          tag_d [P_PRF_COUNT];

  logic [PW-1:0] lo_idx, hi_idx;
  logic          any_free, two_free;
  logic [PW-1:0] offer_prf [2];
  logic [1:0]    offer_rdy;

  // Offers depend on registered state only, so they never react to same-cycle requests.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = P_PRF_COUNT - 1; i >= 0; i--) begin
      if (free_q[i]) lo_idx = PW'(i);
    end
    for (int i = 0; i < P_PRF_COUNT; i++) begin
      if (free_q[i]) hi_idx = PW'(i);
    end
    any_free     = |free_q;
    two_free     = any_free && (lo_idx != hi_idx);
    offer_rdy    = {two_free, any_free};
    offer_prf[0] = any_free ? lo_idx : '0;
    offer_prf[1] = two_free ? hi_idx : '0;
  end

  for (genvar k = 0; k < P_ACQUIRE_PORTS; k++) begin : g_port
    assign bus.o_acquire_prf[k*PW +: PW] = offer_prf[k];
    assign bus.o_acquire_ready[k]        = offer_rdy[k];
  end

  assign bus.o_redeemed_ready = 1'b1;

  always_comb begin
    free_d = free_q;
    spec_d = spec_q;
    tag_d  = tag_q;

    for (int k = 0; k < P_ACQUIRE_PORTS; k++) begin
      if (bus.i_acquire_valid[k] && offer_rdy[k]) begin
        free_d[offer_prf[k]] = 1'b0;
        spec_d[offer_prf[k]] = bus.i_acquire_fgr_speculative[k];
        tag_d[offer_prf[k]]  = bus.i_acquire_fgr[k*GW +: GW];
      end
    end

    if (bus.i_redeemed_valid && (32'(bus.i_redeemed_prf) < P_PRF_COUNT)) begin
      free_d[bus.i_redeemed_prf] = 1'b1;
      spec_d[bus.i_redeemed_prf] = 1'b0;
      tag_d[bus.i_redeemed_prf]  = '0;
    end

    // Abandon is judged on the pre-commit spec bit so it wins over a same-cycle commit.
    for (int i = 0; i < P_PRF_COUNT; i++) begin
      if (!free_d[i] && spec_d[i]) begin
        if (bus.i_abandon_valid && (tag_d[i] == bus.i_abandon_fgr)) begin
          free_d[i] = 1'b1;
          spec_d[i] = 1'b0;
          tag_d[i]  = '0;
        end else if (bus.i_commit_valid && (tag_d[i] == bus.i_commit_fgr)) begin
          spec_d[i] = 1'b0;
          tag_d[i]  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < P_PRF_COUNT; i++) begin
        free_q[i] <= (i >= P_RESET_ALLOCATED);
        spec_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      free_q <= free_d;
      spec_q <= spec_d;
      tag_q  <= tag_d;
    end
  end

`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
  function automatic logic [PW:0] popcount(input logic [P_PRF_COUNT-1:0] v);
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < P_PRF_COUNT; i++) c = c + (PW+1)'(v[i]);
    return c;
  endfunction

  logic [PW:0] free_count_q;

  always_ff @(posedge clk) begin
    if (reset) free_count_q <= (PW+1)'(P_PRF_COUNT - P_RESET_ALLOCATED);
    else       free_count_q <= popcount(free_d);
  end

  assign bus.o_free_count = free_count_q;
`endif
endmodule

// File: tb/tb_issue_rat_freelist_mp.sv
// Bench for issue_rat_freelist_mp: directed scenarios plus random traffic against a bitmap model.
module tb_issue_rat_freelist_mp;
  localparam int N  = 64;
  localparam int G  = 8;
  localparam int RA = 32;
  localparam int AP = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_rat_freelist_mp_if #(.P_PRF_COUNT(N), .P_FGR_COUNT(G), .P_ACQUIRE_PORTS(AP)) bus();

  issue_rat_freelist_mp #(
    .P_PRF_COUNT(N), .P_FGR_COUNT(G), .P_RESET_ALLOCATED(RA), .P_ACQUIRE_PORTS(AP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  bit mfree [N];
  bit mspec [N];
  int mtag  [N];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mfree[i]);
    return c;
  endfunction

  function automatic int m_lo();
    for (int i = 0; i < N; i++) if (mfree[i]) return i;
    return 0;
  endfunction

  function automatic int m_hi();
    for (int i = N - 1; i >= 0; i--) if (mfree[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mfree[i] = (i >= RA);
      mspec[i] = 1'b0;
      mtag[i]  = 0;
    end
  endtask

  task automatic idle();
    reset                         = 1'b0;
    bus.i_redeemed_prf            = '0;
    bus.i_redeemed_valid          = 1'b0;
    bus.i_acquire_fgr             = '0;
    bus.i_acquire_fgr_speculative = '0;
    bus.i_acquire_valid           = '0;
    bus.i_commit_fgr              = '0;
    bus.i_commit_valid            = 1'b0;
    bus.i_abandon_fgr             = '0;
    bus.i_abandon_valid           = 1'b0;
  endtask

  task automatic acq(input logic [1:0] v, input logic [1:0] sp, input int f0, input int f1);
    bus.i_acquire_valid           = v;
    bus.i_acquire_fgr_speculative = sp;
    bus.i_acquire_fgr             = {3'(f1), 3'(f0)};
  endtask

  task automatic check_outputs();
    int c = m_count();
    chk("prf0",  32'(bus.o_acquire_prf[5:0]),  (c >= 1) ? m_lo() : 0);
    chk("prf1",  32'(bus.o_acquire_prf[11:6]), (c >= 2) ? m_hi() : 0);
    chk("ready", 32'(bus.o_acquire_ready), {30'd0, c >= 2, c >= 1});
    chk("redeemed_ready", 32'(bus.o_redeemed_ready), 1);
`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
    chk("free_count", 32'(bus.o_free_count), c);
`endif
  endtask

  // Check current offers, advance one edge, then move the model forward with the same inputs.
  task automatic step();
    int  c, lo, hi, p;
    bit  kill [N];
    check_outputs();
    c  = m_count();
    lo = m_lo();
    hi = m_hi();
    @(posedge clk);
    #1;
    if (reset) begin
      m_reset();
    end else begin
      for (int k = 0; k < AP; k++) begin
        if (bus.i_acquire_valid[k] && (c >= k + 1)) begin
          p = (k == 0) ? lo : hi;
          mfree[p] = 1'b0;
          mspec[p] = bus.i_acquire_fgr_speculative[k];
          mtag[p]  = int'(bus.i_acquire_fgr[k*3 +: 3]);
        end
      end
      if (bus.i_redeemed_valid) begin
        p = int'(bus.i_redeemed_prf);
        mfree[p] = 1'b1;
        mspec[p] = 1'b0;
        mtag[p]  = 0;
      end
      for (int i = 0; i < N; i++)
        kill[i] = !mfree[i] && mspec[i] && bus.i_abandon_valid && (mtag[i] == int'(bus.i_abandon_fgr));
      for (int i = 0; i < N; i++) begin
        if (kill[i]) begin
          mfree[i] = 1'b1;
          mspec[i] = 1'b0;
          mtag[i]  = 0;
        end else if (!mfree[i] && mspec[i] && bus.i_commit_valid && (mtag[i] == int'(bus.i_commit_fgr))) begin
          mspec[i] = 1'b0;
        end
      end
    end
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    idle();

    // Reset values
    do_reset();
    chk("tp_rst_prf0", 32'(bus.o_acquire_prf[5:0]), 32);
    chk("tp_rst_prf1", 32'(bus.o_acquire_prf[11:6]), 63);
    chk("tp_rst_ready", 32'(bus.o_acquire_ready), 3);
`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
    chk("tp_rst_count", 32'(bus.o_free_count), 32);
`endif

    // Drain with dual non-speculative acquires
    for (int c = 0; c < 16; c++) begin
      chk("tp_dual_p0", 32'(bus.o_acquire_prf[5:0]), 32 + c);
      chk("tp_dual_p1", 32'(bus.o_acquire_prf[11:6]), 63 - c);
      acq(2'b11, 2'b00, 0, 0);
      step();
    end
    chk("tp_empty_ready", 32'(bus.o_acquire_ready), 0);
`ifdef ISSUE_RAT_FREELIST_FREE_COUNT_EN
    chk("tp_empty_count", 32'(bus.o_free_count), 0);
`endif
    acq(2'b11, 2'b00, 0, 0);
    step();
    chk("tp_empty_ignored", 32'(bus.o_acquire_ready), 0);

    // Speculative FGR 3 then abandon
    do_reset();
    acq(2'b11, 2'b11, 3, 3);
    step();
    bus.i_abandon_valid = 1'b1;
    bus.i_abandon_fgr   = 3'd3;
    step();
    chk("tp_abandon_prf0", 32'(bus.o_acquire_prf[5:0]), 32);
    chk("tp_abandon_prf1", 32'(bus.o_acquire_prf[11:6]), 63);

    // Commit then abandon leaves PRF allocated; redeem returns it
    acq(2'b01, 2'b01, 5, 0);
    step();
    bus.i_commit_valid = 1'b1;
    bus.i_commit_fgr   = 3'd5;
    step();
    bus.i_abandon_valid = 1'b1;
    bus.i_abandon_fgr   = 3'd5;
    step();
    chk("tp_commit_prf0", 32'(bus.o_acquire_prf[5:0]), 33);
    bus.i_redeemed_valid = 1'b1;
    bus.i_redeemed_prf   = 6'd32;
    step();
    chk("tp_redeem_prf0", 32'(bus.o_acquire_prf[5:0]), 32);

    // Same-cycle acquire+abandon, and commit+abandon together
    acq(2'b01, 2'b01, 2, 0);
    bus.i_abandon_valid = 1'b1;
    bus.i_abandon_fgr   = 3'd2;
    step();
    chk("tp_acq_abandon", 32'(bus.o_acquire_prf[5:0]), 32);
    acq(2'b01, 2'b01, 4, 0);
    step();
    chk("tp_acq4_taken", 32'(bus.o_acquire_prf[5:0]), 33);
    bus.i_commit_valid  = 1'b1;
    bus.i_commit_fgr    = 3'd4;
    bus.i_abandon_valid = 1'b1;
    bus.i_abandon_fgr   = 3'd4;
    step();
    chk("tp_commit_abandon", 32'(bus.o_acquire_prf[5:0]), 32);

    // 31 allocations leave only PRF 40 free
    do_reset();
    for (int c = 0; c < 8; c++) begin
      acq(2'b01, 2'b00, 0, 0);
      step();
    end
    for (int c = 0; c < 23; c++) begin
      acq(2'b10, 2'b00, 0, 0);
      step();
    end
    chk("tp_single_ready", 32'(bus.o_acquire_ready), 1);
    chk("tp_single_prf0", 32'(bus.o_acquire_prf[5:0]), 40);
    acq(2'b10, 2'b00, 0, 0);
    step();
    chk("tp_single_p1_ignored", 32'(bus.o_acquire_prf[5:0]), 40);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      acq(2'($urandom), 2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      bus.i_redeemed_valid = ($urandom_range(0, 99) < 45);
      bus.i_redeemed_prf   = 6'($urandom);
      bus.i_commit_valid   = ($urandom_range(0, 99) < 15);
      bus.i_commit_fgr     = 3'($urandom);
      bus.i_abandon_valid  = ($urandom_range(0, 99) < 10);
      bus.i_abandon_fgr    = 3'($urandom);
      reset                = ($urandom_range(0, 999) < 4);
      step();
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
